// File: rtl/conv2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv2_pkg
// Description : Shared frame geometry defaults, FP32 constants and ReLU helper
// Revision    : 1.0 - initial release
// ============================================================================
package conv2_pkg;

   localparam int C_WIDTH      = 13;
   localparam int C_HEIGHT     = 17;
   localparam int C_FILTER_NUM = 64;

   localparam logic [31:0] FP32_NEG_ZERO = 32'h8000_0000;

   // Any set sign bit (negative zero included) clamps to +0.0
   function automatic logic [31:0] relu(input logic [31:0] x);
      return ((x & FP32_NEG_ZERO) != 32'h0) ? 32'h0 : x;
   endfunction

endpackage
`default_nettype wire

// File: rtl/relu_max2.sv
`default_nettype none
// ============================================================================
// Module      : relu_max2
// Description : Combinational ReLU of two FP32 values, returns the larger one
// Revision    : 1.0 - initial release
// ============================================================================
module relu_max2
   import conv2_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] y
);

   logic [31:0] w_ra;
   logic [31:0] w_rb;

   // Non-negative FP32 values order the same way as their magnitude bits
   always_comb begin
      w_ra = relu(a);
      w_rb = relu(b);
      y    = (w_rb[30:0] > w_ra[30:0]) ? w_rb : w_ra;
   end

endmodule
`default_nettype wire

// File: rtl/conv2_relu_pool.sv
`default_nettype none
// ============================================================================
// Module      : conv2_relu_pool
// Description : Streaming per-lane ReLU followed by 2x2 stride-2 max pooling
// Revision    : 1.0 - initial release
// ============================================================================
module conv2_relu_pool
   import conv2_pkg::*;
#(
   parameter int WIDTH      = C_WIDTH,
   parameter int HEIGHT     = C_HEIGHT,
   parameter int filter_num = C_FILTER_NUM
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         valid_in,
   input  logic [filter_num-1:0][31:0]  data_in,
   output logic                         valid_out,
   output logic [filter_num-1:0][31:0]  data_out,
   output logic                         frame_done
);

   localparam int PW = WIDTH / 2;
   localparam int PH = HEIGHT / 2;
   localparam int WW = $clog2(WIDTH);
   localparam int HW = $clog2(HEIGHT);
   localparam int LW = (PW > 1) ? $clog2(PW) : 1;

   localparam logic [WW-1:0] C_W_LAST = WW'(WIDTH - 1);
   localparam logic [HW-1:0] C_H_LAST = HW'(HEIGHT - 1);
   localparam logic [WW:0]   C_W_LIM  = (WW+1)'(2 * PW);
   localparam logic [HW:0]   C_H_LIM  = (HW+1)'(2 * PH);

   logic [WW-1:0] r_w_idx;
   logic [HW-1:0] r_h_idx;

   logic          w_row_in;
   logic          w_load_hold;
   logic          w_store_line;
   logic          w_emit;
   logic          w_last;
   logic [LW-1:0] w_lb_idx;

   // Trailing odd column/row fall outside every window and are dropped here
   always_comb begin
      w_row_in     = {1'b0, r_h_idx} < C_H_LIM;
      w_load_hold  = valid_in && !r_w_idx[0] && ({1'b0, r_w_idx} < C_W_LIM);
      w_store_line = valid_in &&  r_w_idx[0] && !r_h_idx[0] && w_row_in;
      w_emit       = valid_in &&  r_w_idx[0] &&  r_h_idx[0] && w_row_in;
      w_last       = valid_in && (r_w_idx == C_W_LAST) && (r_h_idx == C_H_LAST);
      w_lb_idx     = LW'(r_w_idx >> 1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_w_idx    <= '0;
         r_h_idx    <= '0;
         valid_out  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         valid_out  <= w_emit;
         frame_done <= w_last;
         if (valid_in) begin
            if (r_w_idx == C_W_LAST) begin
               r_w_idx <= '0;
               r_h_idx <= (r_h_idx == C_H_LAST) ? '0 : r_h_idx + 1'b1;
            end else begin
               r_w_idx <= r_w_idx + 1'b1;
            end
         end
      end
   end

   for (genvar k = 0; k < filter_num; k++) begin : g_lane
      logic [31:0] r_hold;
      logic [31:0] r_line [PW];
      logic [31:0] r_pool;
      logic [31:0] w_pair;
      logic [31:0] w_pool;

      relu_max2 u_pair (
         .a (r_hold),
         .b (data_in[k]),
         .y (w_pair)
      );

      relu_max2 u_pool (
         .a (r_line[w_lb_idx]),
         .b (w_pair),
         .y (w_pool)
      );

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_hold <= '0;
            r_pool <= '0;
            for (int i = 0; i < PW; i++) begin
               r_line[i] <= '0;
            end
         end else begin
            if (w_load_hold) begin
               r_hold <= relu(data_in[k]);
            end
            if (w_store_line) begin
               r_line[w_lb_idx] <= w_pair;
            end
            if (w_emit) begin
               r_pool <= w_pool;
            end
         end
      end

      assign data_out[k] = r_pool;
   end

endmodule
`default_nettype wire

// File: tb/tb_conv2_relu_pool.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv2_relu_pool
// Description : Randomized self-checking bench for conv2_relu_pool
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv2_relu_pool;

   localparam int W    = 13;
   localparam int H    = 17;
   localparam int FN   = 64;
   localparam int NPIX = W * H;
   localparam int PW   = W / 2;
   localparam int PH   = H / 2;
   localparam int NOUT = PW * PH;

   logic                   clk;
   logic                   rst_n;
   logic                   valid_in;
   logic [FN-1:0][31:0]    data_in;
   logic                   valid_out;
   logic [FN-1:0][31:0]    data_out;
   logic                   frame_done;

   logic [31:0] fr      [NPIX][FN];
   logic [31:0] exp_out [NOUT][FN];
   logic [31:0] exp_last[FN];

   int n_checks;
   int n_fail;
   int pulses;
   int fdones;
   int big_seen;

   conv2_relu_pool dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .valid_in   (valid_in),
      .data_in    (data_in),
      .valid_out  (valid_out),
      .data_out   (data_out),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] to_fp32(input int v);
      int          msb;
      logic [31:0] m;
      if (v == 0) return 32'h0;
      msb = 0;
      for (int i = 0; i < 24; i++) if (v[i]) msb = i;
      m = 32'(v) << (23 - msb);
      return {1'b0, 8'(127 + msb), m[22:0]};
   endfunction

   // Reference: max of the four rectified values in each floor-mode window
   task automatic build_expect();
      logic [31:0] v;
      logic [31:0] best;
      for (int oh = 0; oh < PH; oh++)
         for (int ow = 0; ow < PW; ow++)
            for (int k = 0; k < FN; k++) begin
               best = 32'h0;
               for (int dy = 0; dy < 2; dy++)
                  for (int dx = 0; dx < 2; dx++) begin
                     v = fr[(2*oh + dy) * W + 2*ow + dx][k];
                     if (v[31]) v = 32'h0;
                     if (v > best) best = v;
                  end
               exp_out[oh * PW + ow][k] = best;
            end
   endtask

   // One clock: optional beat n, then checks of everything the beat must produce
   task automatic cycle(input bit v, input int n);
      int  h;
      int  w;
      bit  ev;
      bit  efd;
      valid_in = v;
      for (int k = 0; k < FN; k++) data_in[k] = v ? fr[n][k] : $urandom();
      @(posedge clk);
      #1;
      h   = n / W;
      w   = n % W;
      ev  = v && (w % 2 == 1) && (h % 2 == 1) && (h < 2 * PH);
      efd = v && (n == NPIX - 1);
      if (ev)
         for (int k = 0; k < FN; k++) exp_last[k] = exp_out[(h / 2) * PW + w / 2][k];
      check("valid_out", {31'b0, valid_out}, {31'b0, ev});
      check("frame_done", {31'b0, frame_done}, {31'b0, efd});
      for (int k = 0; k < FN; k++) begin
         check("data_out", data_out[k], exp_last[k]);
         if (data_out[k] == 32'h7F00_0000) big_seen++;
      end
      pulses += int'(valid_out);
      fdones += int'(frame_done);
      valid_in = 1'b0;
   endtask

   // gap < 0 selects random 0..2 idle cycles before each beat
   task automatic run_frame(input int gap, input int beats);
      int g;
      build_expect();
      for (int n = 0; n < beats; n++) begin
         g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
         for (int i = 0; i < g; i++) cycle(1'b0, 0);
         cycle(1'b1, n);
      end
   endtask

   task automatic frame_counts(input string tag);
      check({tag, "_pulses"}, 32'(pulses), 32'(NOUT));
      check({tag, "_frame_done"}, 32'(fdones), 32'd1);
      pulses = 0;
      fdones = 0;
   endtask

   task automatic fill_const(input logic [31:0] v);
      for (int n = 0; n < NPIX; n++)
         for (int k = 0; k < FN; k++) fr[n][k] = v;
   endtask

   task automatic fill_random();
      for (int n = 0; n < NPIX; n++)
         for (int k = 0; k < FN; k++) fr[n][k] = $urandom();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      pulses   = 0;
      fdones   = 0;
      big_seen = 0;
      rst_n    = 1'b0;
      valid_in = 1'b0;
      data_in  = '0;
      for (int k = 0; k < FN; k++) exp_last[k] = 32'h0;

      repeat (3) @(posedge clk);
      #1;
      check("reset_valid_out", {31'b0, valid_out}, 32'h0);
      check("reset_frame_done", {31'b0, frame_done}, 32'h0);
      for (int k = 0; k < FN; k++) check("reset_data_out", data_out[k], 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // single larger value in lane 0 at column 1, row 0
      fill_const(32'h3F80_0000);
      fr[1][0] = 32'h4000_0000;
      run_frame(0, NPIX);
      frame_counts("single_peak");

      // negatives and negative zero both clamp to zero
      fill_const(32'hBF80_0000);
      run_frame(0, NPIX);
      frame_counts("neg_one");
      fill_const(32'h8000_0000);
      run_frame(0, NPIX);
      frame_counts("neg_zero");

      // trailing column and row carry a value that must never surface
      fill_const(32'h3F80_0000);
      for (int n = 0; n < NPIX; n++)
         if ((n % W == W - 1) || (n / W == H - 1))
            for (int k = 0; k < FN; k++) fr[n][k] = 32'h7F00_0000;
      big_seen = 0;
      run_frame(0, NPIX);
      frame_counts("edge_drop");
      check("edge_value_seen", 32'(big_seen), 32'h0);

      // identical random frame, contiguous then one beat every third cycle
      fill_random();
      run_frame(0, NPIX);
      frame_counts("rand_contig");
      run_frame(2, NPIX);
      frame_counts("rand_gap3");
      fill_random();
      run_frame(-1, NPIX);
      frame_counts("rand_gaps");

      // reset in the middle of a frame
      fill_random();
      run_frame(0, 100);
      rst_n = 1'b0;
      #1;
      check("midreset_valid_out", {31'b0, valid_out}, 32'h0);
      check("midreset_frame_done", {31'b0, frame_done}, 32'h0);
      for (int k = 0; k < FN; k++) begin
         check("midreset_data_out", data_out[k], 32'h0);
         exp_last[k] = 32'h0;
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      pulses = 0;
      fdones = 0;
      fill_random();
      run_frame(0, NPIX);
      frame_counts("after_reset");

      // two back-to-back ramp frames
      for (int n = 0; n < NPIX; n++)
         for (int k = 0; k < FN; k++) fr[n][k] = to_fp32(n + k);
      run_frame(0, NPIX);
      frame_counts("ramp_a");
      run_frame(0, NPIX);
      frame_counts("ramp_b");

      repeat (2) cycle(1'b0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/conv2_relu_pool.md
CONV2_RELU_POOL -- requirements
Module: conv2_relu_pool

Interface
REQ-001 SHALL have parameter WIDTH, default 13, meaning input frame columns.
REQ-002 SHALL have parameter HEIGHT, default 17, meaning input frame rows.
REQ-003 SHALL have parameter filter_num, default 64, meaning parallel FP32 lanes, one per filter.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning reset, asynchronous, active-low.
REQ-006 SHALL have port valid_in, input, 1, meaning data_in carries one raster-order pixel this cycle.
REQ-007 SHALL have port data_in, input, [31:0] x filter_num, meaning accumulated IEEE-754 FP32 value per lane.
REQ-008 SHALL have port valid_out, input-side independent output, 1, meaning data_out holds a new pooled pixel (one-cycle pulse).
REQ-009 SHALL have port data_out, output, [31:0] x filter_num, meaning pooled FP32 value per lane.
REQ-010 SHALL have port frame_done, output, 1, meaning one-cycle pulse after the last input pixel of a frame.

Function
REQ-011 SHALL apply ReLU per lane: any value with bit 31 set (including 0x80000000) becomes 0x00000000.
REQ-012 SHALL compare post-ReLU values as 31-bit unsigned integers (valid for non-negative FP32); no FP arithmetic unit.
REQ-013 SHALL track column w_idx (0..WIDTH-1) and row h_idx (0..HEIGHT-1), advancing only on valid_in; w wraps to 0 and increments h; after (WIDTH-1,HEIGHT-1) both wrap to 0.
REQ-014 SHALL perform 2x2 max pool, stride 2, floor mode: output is (WIDTH/2) x (HEIGHT/2) = 6 x 8 = 48 pixels per frame at defaults.
REQ-015 SHALL, on even w < 2*(WIDTH/2), register relu(data_in) per lane into a horizontal hold register.
REQ-016 SHALL, on odd w, form pair = max(hold, relu(data_in)); on even h store pair into line buffer entry w>>1 (WIDTH/2 entries x filter_num lanes).
REQ-017 SHALL, on odd w and odd h < 2*(HEIGHT/2), output max(line_buffer[w>>1], pair).
REQ-018 SHALL ignore data at w = WIDTH-1 when WIDTH is odd and at h = HEIGHT-1 when HEIGHT is odd; counters still advance.
REQ-019 SHALL assert valid_out exactly one cycle after the valid_in beat that completes a window; latency 1 cycle, registered output.
REQ-020 SHALL hold data_out at its last value while valid_out is low.
REQ-021 SHALL assert frame_done one cycle after the valid_in beat at (WIDTH-1,HEIGHT-1), simultaneous with nothing else being dropped.
REQ-022 SHALL accept arbitrary gaps in valid_in; gaps do not change results; no backpressure exists.
REQ-023 SHALL accept back-to-back frames with no idle cycle between last and first pixel.

Reset
REQ-024 SHALL, on rst_n low, asynchronously clear valid_out, frame_done, data_out, w_idx, h_idx, hold registers and line buffer to 0.
REQ-025 SHALL, on reset mid-frame, discard partial windows; the next valid_in is pixel (0,0) of a new frame.

Structure
REQ-026 SHALL take WIDTH, HEIGHT, filter_num defaults and constant FP32_NEG_ZERO = 0x80000000 from shared package conv2_pkg.
REQ-027 SHALL instantiate one per-lane sub-module relu_max2 (combinational: ReLU both FP32 inputs, return larger).

Verification
REQ-028 SHALL test: all lanes 0x3F800000 except lane 0 pixel (1,0) = 0x40000000 -> first valid_out lane 0 = 0x40000000, other lanes 0x3F800000; 48 valid_out pulses; frame_done once after beat 221.
REQ-029 SHALL test: every input 0xBF800000, then every input 0x80000000 -> all 48 outputs 0x00000000 on all lanes.
REQ-030 SHALL test: column 12 and row 16 set to 0x7F000000, rest 0x3F800000 -> 0x7F000000 never appears on data_out.
REQ-031 SHALL test: same frame with valid_in every third cycle -> output values identical to contiguous run, each valid_out 1 cycle after its closing beat.
REQ-032 SHALL test: rst_n pulsed low after 100 beats -> valid_out 0 immediately; following full frame yields exactly 48 correct outputs and one frame_done.
REQ-033 SHALL test: two back-to-back frames, ramp values (pixel n lane k = FP32 of n+k) -> each output equals FP32 of bottom-right window index + k.
